// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter slice: RAM handshake states and
// arbiter FSM states.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_link_reg.sv
// LL/SC link register: remembers the address of the last load-linked and
// whether the reservation is still valid. A set and a clear in the same cycle
// resolve in favour of the set.
module link_reg
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              i_set,
    input  logic              i_clear,
    input  logic [WORD_W-1:0] i_setAddr,
    input  logic [WORD_W-1:0] i_cmpAddr,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_addr,
    output logic              o_match
);

    logic              r_valid;
    logic [WORD_W-1:0] r_addr;

    // Reservation state: set wins over clear, reset drops the reservation.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
        end else if (i_set) begin
            r_valid <= 1'b1;
            r_addr  <= i_setAddr;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_addr  = r_addr;
    assign o_match = r_valid && (r_addr == i_cmpAddr);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch (I) and data (D) paths.
// D has priority, but after STARVE_LIMIT consecutive D grants with I pending
// the I side is forced through. Also owns the LL/SC reservation.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int WORD_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic              datomic,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  ramstate_t         ramstate
);

    localparam int            CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
    localparam logic [WORD_W-1:0] ONE_C  = WORD_W'(1);

    arb_state_t       r_state;
    arb_state_t       w_nextState;
    logic [CNT_W-1:0] r_starveCnt;

    logic w_dReq;
    logic w_ll;
    logic w_sc;
    logic w_dDone;
    logic w_iDone;
    logic w_linkSet;
    logic w_linkClear;
    logic w_linkValid;
    logic w_linkMatch;
    logic [WORD_W-1:0] w_linkAddr;

    assign w_dReq = dREN | dWEN;
    assign w_ll   = dREN & datomic;
    assign w_sc   = dWEN & datomic;

    link_reg #(.WORD_W(WORD_W)) u_linkReg (
        .CLK       (CLK),
        .nRST      (nRST),
        .i_set     (w_linkSet),
        .i_clear   (w_linkClear),
        .i_setAddr (daddr),
        .i_cmpAddr (daddr),
        .o_valid   (w_linkValid),
        .o_addr    (w_linkAddr),
        .o_match   (w_linkMatch)
    );

    // Arbiter state register; the grant decision is taken in IDLE and held here.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    // Count back-to-back D completions while I waits; cleared by an I completion or I idling.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                              r_starveCnt <= '0;
        else if (!iREN || w_iDone)              r_starveCnt <= '0;
        else if (w_dDone && r_starveCnt < LIMIT_C) r_starveCnt <= r_starveCnt + 1'b1;
    end

    // Next-state, RAM strobes, handshakes and link-register updates.
    always_comb begin
        w_nextState = r_state;
        iwait       = 1'b1;
        dwait       = 1'b1;
        iload       = '0;
        dload       = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        w_dDone     = 1'b0;
        w_iDone     = 1'b0;
        w_linkSet   = 1'b0;
        w_linkClear = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_dReq && (r_starveCnt < LIMIT_C)) w_nextState = DGRANT;
                else if (iREN)                         w_nextState = IGRANT;
            end
            DGRANT: begin
                if (!w_dReq) begin
                    w_nextState = IDLE;
                end else if (w_sc && !w_linkMatch) begin
                    dwait       = 1'b0;
                    w_dDone     = 1'b1;
                    w_linkClear = 1'b1;
                    w_nextState = IDLE;
                end else begin
                    ramREN   = dREN;
                    ramWEN   = dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (ramstate == ACCESS) begin
                        dwait       = 1'b0;
                        w_dDone     = 1'b1;
                        w_nextState = IDLE;
                        if (w_sc)      dload = ONE_C;
                        else if (dREN) dload = ramload;
                        if (w_ll) w_linkSet = 1'b1;
                        if (dWEN && w_linkMatch) w_linkClear = 1'b1;
                    end
                end
            end
            IGRANT: begin
                if (!iREN) begin
                    w_nextState = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ramstate == ACCESS) begin
                        iwait       = 1'b0;
                        iload       = ramload;
                        w_iDone     = 1'b1;
                        w_nextState = IDLE;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    logic w_unusedLink;
    assign w_unusedLink = w_linkValid ^ (^w_linkAddr);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, I-only fetch, D/I contention,
// starvation guard, LL/SC outcomes, withdrawal and mid-transaction reset.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN, datomic;
    logic [31:0] iaddr, daddr, dstore, ramload;
    ramstate_t   ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int nTests = 0;
    int nFail  = 0;

    mem_arbiter #(.WORD_W(32), .STARVE_LIMIT(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .datomic(datomic), .daddr(daddr),
        .dstore(dstore), .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clearInputs();
        iREN = 0; dREN = 0; dWEN = 0; datomic = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
    endtask

    task automatic test_reset();
        clearInputs();
        nRST = 0;
        #3;
        nTests++; if (iwait !== 1'b1)   begin $display("[TB] FAIL reset_iwait: got %b expected 1", iwait); nFail++; end
        nTests++; if (dwait !== 1'b1)   begin $display("[TB] FAIL reset_dwait: got %b expected 1", dwait); nFail++; end
        nTests++; if ({ramREN, ramWEN} !== 2'b00) begin $display("[TB] FAIL reset_strobes: got %b expected 00", {ramREN, ramWEN}); nFail++; end
        nTests++; if (ramaddr !== 32'h0 || iload !== 32'h0 || dload !== 32'h0) begin
            $display("[TB] FAIL reset_buses: got %h/%h/%h expected 0/0/0", ramaddr, iload, dload); nFail++; end
        tick(); tick();
        nRST = 1;
        tick();
    endtask

    task automatic test_ionly();
        iREN = 1; iaddr = 32'h40; ramstate = BUSY; ramload = 32'hDEADBEEF;
        #1;
        nTests++; if (ramREN !== 1'b0) begin $display("[TB] FAIL ionly_idle_ren: got %b expected 0", ramREN); nFail++; end
        tick(); #1;
        nTests++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin
            $display("[TB] FAIL ionly_grant: got ren=%b addr=%h expected ren=1 addr=40", ramREN, ramaddr); nFail++; end
        nTests++; if (iwait !== 1'b1) begin $display("[TB] FAIL ionly_busy_wait: got %b expected 1", iwait); nFail++; end
        tick(); #1;
        nTests++; if (iwait !== 1'b1) begin $display("[TB] FAIL ionly_busy2_wait: got %b expected 1", iwait); nFail++; end
        tick(); ramstate = ACCESS; #1;
        nTests++; if (iwait !== 1'b0 || iload !== 32'hDEADBEEF) begin
            $display("[TB] FAIL ionly_done: got wait=%b load=%h expected wait=0 load=deadbeef", iwait, iload); nFail++; end
        tick(); #1;
        nTests++; if (iwait !== 1'b1 || ramREN !== 1'b0) begin
            $display("[TB] FAIL ionly_one_cycle: got wait=%b ren=%b expected wait=1 ren=0", iwait, ramREN); nFail++; end
        clearInputs();
        tick();
    endtask

    task automatic test_simultaneous();
        iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h200; ramload = 32'h11112222; ramstate = ACCESS;
        #1;
        nTests++; if (dwait !== 1'b1 || iwait !== 1'b1) begin
            $display("[TB] FAIL sim_idle_waits: got d=%b i=%b expected 1 1", dwait, iwait); nFail++; end
        tick(); #1;
        nTests++; if (dwait !== 1'b0 || dload !== 32'h11112222 || ramaddr !== 32'h200) begin
            $display("[TB] FAIL sim_d_first: got dwait=%b dload=%h addr=%h expected 0 11112222 200", dwait, dload, ramaddr); nFail++; end
        nTests++; if (iwait !== 1'b1) begin $display("[TB] FAIL sim_i_held: got %b expected 1", iwait); nFail++; end
        tick(); dREN = 0; #1;
        nTests++; if (iwait !== 1'b1 || ramREN !== 1'b0) begin
            $display("[TB] FAIL sim_rearb: got iwait=%b ren=%b expected 1 0", iwait, ramREN); nFail++; end
        tick(); #1;
        nTests++; if (iwait !== 1'b0 || ramaddr !== 32'h44) begin
            $display("[TB] FAIL sim_i_second: got iwait=%b addr=%h expected 0 44", iwait, ramaddr); nFail++; end
        clearInputs();
        tick();
    endtask

    task automatic test_starvation();
        int dCount = 0;
        bit iSeen = 0;
        iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h300; ramstate = ACCESS;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (iwait === 1'b0) begin iSeen = 1; break; end
            if (dwait === 1'b0) dCount++;
            tick();
        end
        nTests++; if (!iSeen) begin $display("[TB] FAIL starve_i_granted: got 0 expected 1"); nFail++; end
        nTests++; if (dCount != 4) begin $display("[TB] FAIL starve_d_count: got %0d expected 4", dCount); nFail++; end
        tick(); tick(); #1;
        nTests++; if (dwait !== 1'b0 || iwait !== 1'b1) begin
            $display("[TB] FAIL starve_cnt_reset: got dwait=%b iwait=%b expected 0 1", dwait, iwait); nFail++; end
        clearInputs();
        tick();
    endtask

    task automatic test_ll_sc();
        dREN = 1; datomic = 1; daddr = 32'h100; ramstate = ACCESS; ramload = 32'h5;
        tick(); #1;
        nTests++; if (dwait !== 1'b0) begin $display("[TB] FAIL llsc_ll_done: got %b expected 0", dwait); nFail++; end
        tick(); dREN = 0; dWEN = 1; dstore = 32'hABCD; #1;
        nTests++; if (ramWEN !== 1'b0) begin $display("[TB] FAIL llsc_idle_wen: got %b expected 0", ramWEN); nFail++; end
        tick(); #1;
        nTests++; if (ramWEN !== 1'b1 || ramstore !== 32'hABCD || dwait !== 1'b0 || dload !== 32'h1) begin
            $display("[TB] FAIL llsc_sc_ok: got wen=%b store=%h dwait=%b dload=%h expected 1 abcd 0 1", ramWEN, ramstore, dwait, dload); nFail++; end
        tick(); tick(); #1;
        nTests++; if (ramWEN !== 1'b0 || dwait !== 1'b0 || dload !== 32'h0) begin
            $display("[TB] FAIL llsc_second_sc: got wen=%b dwait=%b dload=%h expected 0 0 0", ramWEN, dwait, dload); nFail++; end
        clearInputs();
        tick();
    endtask

    task automatic test_ll_write_sc();
        dREN = 1; datomic = 1; daddr = 32'h100; ramstate = ACCESS;
        tick(); tick();
        dREN = 0; dWEN = 1; datomic = 0; dstore = 32'h77;
        tick(); #1;
        nTests++; if (ramWEN !== 1'b1 || dwait !== 1'b0) begin
            $display("[TB] FAIL llw_plain_write: got wen=%b dwait=%b expected 1 0", ramWEN, dwait); nFail++; end
        tick(); datomic = 1;
        tick(); #1;
        nTests++; if (ramWEN !== 1'b0 || dwait !== 1'b0 || dload !== 32'h0) begin
            $display("[TB] FAIL llw_sc_fail: got wen=%b dwait=%b dload=%h expected 0 0 0", ramWEN, dwait, dload); nFail++; end
        clearInputs();
        tick();
    endtask

    task automatic test_sc_no_ll();
        dWEN = 1; datomic = 1; daddr = 32'h300; dstore = 32'h9; ramstate = BUSY;
        #1;
        nTests++; if (dwait !== 1'b1 || ramWEN !== 1'b0) begin
            $display("[TB] FAIL scnoll_first: got dwait=%b wen=%b expected 1 0", dwait, ramWEN); nFail++; end
        tick(); #1;
        nTests++; if (dwait !== 1'b0 || ramWEN !== 1'b0 || dload !== 32'h0) begin
            $display("[TB] FAIL scnoll_second: got dwait=%b wen=%b dload=%h expected 0 0 0", dwait, ramWEN, dload); nFail++; end
        clearInputs();
        tick();
    endtask

    task automatic test_withdrawal();
        dREN = 1; daddr = 32'h600; ramstate = BUSY;
        tick(); #1;
        nTests++; if (ramREN !== 1'b1) begin $display("[TB] FAIL wd_granted: got %b expected 1", ramREN); nFail++; end
        dREN = 0; #1;
        nTests++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin
            $display("[TB] FAIL wd_drop: got ren=%b dwait=%b expected 0 1", ramREN, dwait); nFail++; end
        tick(); ramstate = ACCESS; #1;
        nTests++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin
            $display("[TB] FAIL wd_idle: got ren=%b dwait=%b expected 0 1", ramREN, dwait); nFail++; end
        clearInputs();
        tick();
    endtask

    task automatic test_reset_mid();
        dREN = 1; datomic = 1; daddr = 32'h180; ramstate = ACCESS;
        tick(); tick();
        datomic = 0; daddr = 32'h500; ramstate = BUSY;
        tick(); #1;
        nTests++; if (ramREN !== 1'b1) begin $display("[TB] FAIL rmid_granted: got %b expected 1", ramREN); nFail++; end
        nRST = 0; #1;
        nTests++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dwait !== 1'b1) begin
            $display("[TB] FAIL rmid_strobes: got ren=%b wen=%b dwait=%b expected 0 0 1", ramREN, ramWEN, dwait); nFail++; end
        dREN = 0; ramstate = ACCESS;
        tick();
        nRST = 1;
        tick();
        dWEN = 1; datomic = 1; daddr = 32'h180; dstore = 32'h3;
        tick(); #1;
        nTests++; if (ramWEN !== 1'b0 || dwait !== 1'b0 || dload !== 32'h0) begin
            $display("[TB] FAIL rmid_sc_fail: got wen=%b dwait=%b dload=%h expected 0 0 0", ramWEN, dwait, dload); nFail++; end
        clearInputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_ionly();
        test_simultaneous();
        test_starvation();
        test_ll_sc();
        test_ll_write_sc();
        test_sc_no_ll();
        test_withdrawal();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
